// File: rtl/dadda_unsigned_multiplier_rca_64.sv
// 64x64 unsigned multiplier: AND-array partial products, Dadda reduction
// tree of full/half adders down to two rows, ripple-carry final adder,
// registered 128-bit product.
// Build option: define DADDA_MUL_IN_REG_EN to register A and B ahead of the
// tree (latency 2); otherwise latency is 1. Throughput is 1/cycle either way.
module dadda_unsigned_multiplier_rca_64 (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  A,
    input  logic [63:0]  B,
    output logic [127:0] product
);

    localparam int unsigned W      = 64;
    localparam int unsigned PW     = 2 * W;
    localparam int unsigned MAXH   = W;
    localparam int unsigned CW     = $clog2(PW);
    localparam int unsigned HW     = $clog2(MAXH);
    localparam int unsigned NSTAGE = 10;

    // Dadda target heights, largest first (max column height is 64).
    localparam int DH [NSTAGE] = '{63, 42, 28, 19, 13, 9, 6, 4, 3, 2};

    logic [W-1:0]    a_s;
    logic [W-1:0]    b_s;

    logic [MAXH-1:0] cur [PW];
    logic [MAXH-1:0] nxt [PW];
    int              ch  [PW];
    int              nh  [PW];
    logic [PW-1:0]   row0;
    logic [PW-1:0]   row1;
    logic [PW-1:0]   sum_c;

`ifdef DADDA_MUL_IN_REG_EN
    // Operand input registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s <= '0;
            b_s <= '0;
        end else begin
            a_s <= A;
            b_s <= B;
        end
    end
`else
    // Operands feed the tree directly.
    always_comb begin
        a_s = A;
        b_s = B;
    end
`endif

    // Partial-product generation and Dadda column reduction to two rows.
    always_comb begin
        int  r;
        int  k;
        logic sm;
        logic cy;

        r  = 0;
        k  = 0;
        sm = 1'b0;
        cy = 1'b0;
        for (int c = 0; c < PW; c++) begin
            cur[c] = '0;
            nxt[c] = '0;
            ch[c]  = 0;
            nh[c]  = 0;
        end

        // Each column holds its bits packed from index 0 upward.
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                cur[CW'(i + j)][HW'(ch[CW'(i + j)])] = a_s[i] & b_s[j];
                ch[CW'(i + j)] = ch[CW'(i + j)] + 1;
            end
        end

        for (int s = 0; s < NSTAGE; s++) begin
            for (int c = 0; c < PW; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            // Columns ascending: nh[c] already counts carries from column c-1.
            for (int c = 0; c < PW; c++) begin
                r = ch[c];
                k = 0;
                for (int t = 0; t < MAXH; t++) begin
                    if (r + nh[c] > DH[s]) begin
                        if ((r + nh[c] - DH[s] >= 2) && (r >= 3)) begin
                            {cy, sm} = 2'(cur[c][HW'(k)]) + 2'(cur[c][HW'(k + 1)])
                                     + 2'(cur[c][HW'(k + 2)]);
                            k = k + 3;
                            r = r - 3;
                        end else begin
                            {cy, sm} = 2'(cur[c][HW'(k)]) + 2'(cur[c][HW'(k + 1)]);
                            k = k + 2;
                            r = r - 2;
                        end
                        nxt[c][HW'(nh[c])] = sm;
                        nh[c] = nh[c] + 1;
                        if (c < PW - 1) begin
                            nxt[CW'(c + 1)][HW'(nh[CW'(c + 1)])] = cy;
                            nh[CW'(c + 1)] = nh[CW'(c + 1)] + 1;
                        end
                    end
                end
                // Untouched bits pass straight through to the next stage.
                for (int t = 0; t < MAXH; t++) begin
                    if ((t >= k) && (t < ch[c])) begin
                        nxt[c][HW'(nh[c])] = cur[c][HW'(t)];
                        nh[c] = nh[c] + 1;
                    end
                end
            end
            for (int c = 0; c < PW; c++) begin
                cur[c] = nxt[c];
                ch[c]  = nh[c];
            end
        end

        for (int c = 0; c < PW; c++) begin
            row0[c] = cur[c][0];
            row1[c] = cur[c][1];
        end
    end

    // Ripple-carry adder over the two remaining rows; carry-out lands in bit 127.
    always_comb begin
        logic rc;
        rc = 1'b0;
        for (int c = 0; c < PW - 1; c++) begin
            sum_c[c] = row0[c] ^ row1[c] ^ rc;
            rc       = (row0[c] & row1[c]) | (rc & (row0[c] ^ row1[c]));
        end
        sum_c[PW-1] = rc ^ row0[PW-1] ^ row1[PW-1];
    end

    // Product register; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
        end else begin
            product <= sum_c;
        end
    end

endmodule

// File: tb/tb_dadda_unsigned_multiplier_rca_64.sv
// Scoreboard bench for dadda_unsigned_multiplier_rca_64: a driver issues one
// operand pair per cycle and queues the expected product; a monitor on the
// falling edge pops and compares. Honours DADDA_MUL_IN_REG_EN for latency.
module tb_dadda_unsigned_multiplier_rca_64;

`ifdef DADDA_MUL_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [63:0]  ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] MAX_SQ = 128'hFFFFFFFFFFFFFFFE0000000000000001;

    typedef struct {
        logic         r;
        logic [63:0]  a;
        logic [63:0]  b;
        logic         use_k;
        logic [127:0] k;
        string        nm;
    } stim_t;

    typedef struct {
        int           due;
        logic [127:0] exp;
        string        nm;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [63:0]  A;
    logic [63:0]  B;
    logic [127:0] product;

    stim_t hist[$];
    exp_t  sb[$];
    int    edges;
    int    total;
    int    bad;

    dadda_unsigned_multiplier_rca_64 dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edges = 0;
    always @(posedge clk) edges <= edges + 1;

    // Drive one cycle of stimulus and queue what the output must be after the
    // coming edge: zero if reset appeared in the last LAT edges, otherwise the
    // product of the operands captured LAT-1 edges earlier.
    task automatic issue(input logic r, input logic [63:0] a, input logic [63:0] b,
                         input string nm, input logic use_k, input logic [127:0] k);
        stim_t st;
        exp_t  e;
        logic  any_rst;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        st.r = r; st.a = a; st.b = b; st.use_k = use_k; st.k = k; st.nm = nm;
        hist.push_back(st);
        while (hist.size() > LAT) void'(hist.pop_front());
        any_rst = (hist.size() < LAT);
        foreach (hist[i]) if (hist[i].r) any_rst = 1'b1;
        e.due = edges + 1;
        e.nm  = hist[0].nm;
        if (any_rst)
            e.exp = '0;
        else if (hist[0].use_k)
            e.exp = hist[0].k;
        else
            e.exp = {64'd0, hist[0].a} * {64'd0, hist[0].b};
        sb.push_back(e);
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        int unsigned mode;
        mode = $urandom_range(0, 9);
        case (mode)
            0:       v = '0;
            1:       v = ONES;
            2:       v = 64'd1 << $urandom_range(0, 63);
            3:       v = ONES >> $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Monitor: compare whenever an expected result falls due.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == edges) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (product !== e.exp) begin
                bad++;
                $display("FAIL %s edge=%0d got=%h want=%h", e.nm, edges, product, e.exp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at edge %0d", edges);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        A     = ONES;
        B     = ONES;

        issue(1'b1, ONES, ONES, "rst_hold0", 1'b0, '0);
        issue(1'b1, ONES, ONES, "rst_hold1", 1'b0, '0);
        issue(1'b0, ONES, ONES, "max_sq", 1'b1, MAX_SQ);
        issue(1'b0, 64'h0, 64'h0, "zero_zero", 1'b1, 128'h0);
        issue(1'b0, 64'h3489BE8F00000000, 64'h00000000FFFFFFFF, "mixed",
              1'b1, 128'h000000003489BE8ECB76417100000000);
        issue(1'b0, 64'h8000000000000000, 64'd2, "carry64",
              1'b1, 128'h00000000000000010000000000000000);
        issue(1'b0, 64'd1, 64'hAB5BAFFF00000FD3, "ident",
              1'b1, 128'h0000000000000000AB5BAFFF00000FD3);
        issue(1'b0, 64'd0, 64'hFFF1001000000000, "zero_a", 1'b1, 128'h0);
        issue(1'b0, ONES, 64'd1, "ones_x1", 1'b1, {64'd0, ONES});

        // Mid-stream reset with live operands: results in flight must vanish.
        issue(1'b1, ONES, ONES, "mid_rst0", 1'b0, '0);
        issue(1'b0, 64'd3, 64'd5, "post_rst", 1'b1, 128'd15);
        issue(1'b0, ONES, ONES, "b2b0", 1'b1, MAX_SQ);
        issue(1'b0, 64'd7, 64'd9, "b2b1", 1'b1, 128'd63);
        issue(1'b0, 64'h1_0000_0000, 64'h1_0000_0000, "b2b2",
              1'b1, 128'h1_0000_0000_0000_0000);

        for (int n = 0; n < 10000; n++) begin
            logic r;
            r = ($urandom_range(0, 999) == 0);
            issue(r, rand_op(), rand_op(), r ? "rand_rst" : "rand", 1'b0, '0);
        end

        repeat (LAT + 3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
